// File: rtl/ripple_count_sampler.sv
// Samples the staggered bits of an asynchronous ripple counter into the clk domain,
// accepts a value once it has been steady long enough, and accumulates the steps.
module ripple_count_sampler #(
  parameter int             CW       = 3,
  parameter int             STABLE   = 2,
  parameter int             EXT_W    = 16,
  parameter logic [CW-1:0]  INIT_CNT = 3'b111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    cnt_in,
  input  logic             clear,
  output logic [CW-1:0]    cnt_stable,
  output logic [EXT_W-1:0] ext_count,
  output logic [CW-1:0]    delta,
  output logic             upd,
  output logic             ovf,
  output logic [7:0]       glitch_cnt,
  output logic             fsm_state
);

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [3:0] STABLE_L = 4'(STABLE);

  state_t          state;
  logic [CW-1:0]   sync1;
  logic [CW-1:0]   sync2;
  logic [CW-1:0]   cand;
  logic [3:0]      stab_cnt;
  logic [3:0]      stab_next;
  logic [CW-1:0]   d;
  logic [EXT_W:0]  sum;
  logic            accept;
  logic            reject;

  // The counter only counts up, so the modular difference is the step size.
  always_comb begin
    d         = cand - cnt_stable;
    sum       = {1'b0, ext_count} + (EXT_W+1)'(d);
    stab_next = stab_cnt + 4'd1;
    accept    = (state == TRACK) && (sync2 == cand) && (stab_next == STABLE_L);
    reject    = (state == TRACK) && (sync2 != cand);
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= INIT_CNT;
      sync2      <= INIT_CNT;
      cand       <= INIT_CNT;
      cnt_stable <= INIT_CNT;
      stab_cnt   <= '0;
      state      <= IDLE;
      ext_count  <= '0;
      delta      <= '0;
      upd        <= 1'b0;
      ovf        <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      sync1 <= cnt_in;
      sync2 <= sync1;
      upd   <= 1'b0;

      case (state)
        IDLE: begin
          if (sync2 != cnt_stable) begin
            cand     <= sync2;
            stab_cnt <= 4'd1;
            state    <= TRACK;
          end
        end
        TRACK: begin
          if (sync2 == cand) begin
            if (accept) begin
              stab_cnt <= '0;
              state    <= IDLE;
            end else begin
              stab_cnt <= stab_next;
            end
          end else if (sync2 == cnt_stable) begin
            state <= IDLE;
          end else begin
            cand     <= sync2;
            stab_cnt <= 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        cnt_stable <= cand;
        delta      <= d;
        upd        <= !clear;
      end

      // clear wins over a same-cycle accumulate or reject.
      if (clear) begin
        ext_count  <= '0;
        ovf        <= 1'b0;
        glitch_cnt <= '0;
      end else begin
        if (accept) begin
          ext_count <= sum[EXT_W-1:0];
          if (sum[EXT_W]) ovf <= 1'b1;
        end
        if (reject && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed plus randomized bench for ripple_count_sampler with a behavioural step model.
module tb_ripple_count_sampler;

  localparam int STABLE = 2;
  localparam int EXT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       cnt_in = 3'd7;
  logic             clear = 1'b0;
  logic [2:0]       cnt_stable;
  logic [EXT_W-1:0] ext_count;
  logic [2:0]       delta;
  logic             upd;
  logic             ovf;
  logic [7:0]       glitch_cnt;
  logic             fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: value-level view of the sampler.
  logic [2:0] m_stable = 3'd7;
  logic [2:0] m_delta  = 3'd0;
  int         m_ext    = 0;
  logic       m_ovf    = 1'b0;
  int         m_glitch = 0;

  ripple_count_sampler #(.CW(3), .STABLE(STABLE), .EXT_W(EXT_W), .INIT_CNT(3'b111)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .clear(clear),
    .cnt_stable(cnt_stable), .ext_count(ext_count), .delta(delta), .upd(upd),
    .ovf(ovf), .glitch_cnt(glitch_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_stable"}, 16'(cnt_stable), 16'(m_stable));
    chk({tag, "_ext"},    16'(ext_count),  16'(m_ext));
    chk({tag, "_delta"},  16'(delta),      16'(m_delta));
    chk({tag, "_ovf"},    16'(ovf),        16'(m_ovf));
    chk({tag, "_glitch"}, 16'(glitch_cnt), 16'(m_glitch));
  endtask

  // Hold v for n edges (n >= STABLE+2); optionally pulse clear before edge clr_at.
  task automatic hold_val(input logic [2:0] v, input int n, input int clr_at);
    logic       chg;
    logic       acc;
    logic [2:0] dd;
    int         s;
    @(negedge clk);
    cnt_in = v;
    chg = (v != m_stable);
    for (int i = 1; i <= n; i++) begin
      if (i > 1) @(negedge clk);
      clear = (i == clr_at);
      @(posedge clk);
      #1;
      acc = chg && (i == 2 + STABLE);
      if (acc) begin
        dd = v - m_stable;
        m_stable = v;
        m_delta = dd;
        s = m_ext + int'(dd);
      end else begin
        s = m_ext;
      end
      if (clear) begin
        m_ext = 0;
        m_ovf = 1'b0;
        m_glitch = 0;
      end else if (acc) begin
        m_ext = s % (1 << EXT_W);
        if (s >= (1 << EXT_W)) m_ovf = 1'b1;
      end
      chk("upd", 16'(upd), 16'(acc && !clear));
      if (chg && i == 3) chk("track", 16'(fsm_state), 16'd1);
      if (acc) chk_status("accept");
      clear = 1'b0;
    end
    chk_status("hold");
  endtask

  // Drive v for n edges with no timing expectation; counts upd pulses seen.
  task automatic drive_raw(input logic [2:0] v, input int n, inout int ups);
    @(negedge clk);
    cnt_in = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (upd) ups++;
    end
  endtask

  initial begin
    int ups;
    logic [2:0] rv;

    // Reset state
    rst_n = 1'b0;
    cnt_in = 3'd7;
    #12;
    chk_status("reset");
    chk("reset_upd", 16'(upd), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset idle
    hold_val(3'd7, 20, 0);

    // Single steps including the 7->0 wrap
    hold_val(3'd0, 10, 0);
    hold_val(3'd1, 10, 0);
    hold_val(3'd2, 10, 0);

    // Single-cycle glitch back to the stable value
    ups = 0;
    drive_raw(3'd6, 1, ups);
    drive_raw(3'd2, 8, ups);
    m_glitch = 1;
    chk("glitch1_upd", 16'(ups), 16'd0);
    chk_status("glitch1");

    // Ripple sequence 3->2->0->4 settles as one +2 step with two rejects
    ups = 0;
    drive_raw(3'd3, 1, ups);
    drive_raw(3'd2, 1, ups);
    drive_raw(3'd0, 1, ups);
    drive_raw(3'd4, 8, ups);
    m_glitch = 3;
    m_delta = 3'd2;
    m_stable = 3'd4;
    m_ext = m_ext + 2;
    chk("ripple_upd", 16'(ups), 16'd1);
    chk_status("ripple");

    // Multi-step 4->1 gives delta 5
    hold_val(3'd1, 10, 0);

    // clear on the accept edge of a step to 5
    hold_val(3'd5, 8, 2 + STABLE);

    // Overflow: 16 single steps from 0 wraps the 4-bit count, ovf stays sticky
    for (int k = 0; k < 17; k++) hold_val(3'(m_stable + 3'd1), 5, 0);
    chk("ovf_sticky", 16'(ovf), 16'd1);
    hold_val(m_stable, 4, 1);
    chk("ovf_cleared", 16'(ovf), 16'd0);

    // Randomized holds long enough to be accepted
    for (int k = 0; k < 25; k++) begin
      rv = 3'($urandom_range(0, 7));
      hold_val(rv, $urandom_range(4, 8), ($urandom_range(0, 5) == 0) ? 2 + STABLE : 0);
    end

    // Reset mid-TRACK discards the candidate asynchronously
    @(negedge clk);
    cnt_in = 3'(m_stable + 3'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_track", 16'(fsm_state), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    m_stable = 3'd7;
    m_delta = 3'd0;
    m_ext = 0;
    m_ovf = 1'b0;
    m_glitch = 0;
    chk_status("async_reset");
    chk("async_reset_upd", 16'(upd), 16'd0);
    chk("async_reset_state", 16'(fsm_state), 16'd0);
    cnt_in = 3'd7;
    @(negedge clk);
    rst_n = 1'b1;
    hold_val(3'd7, 6, 0);
    hold_val(3'd3, 6, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
